// File: rtl/mem_stream_loader.sv
// Purpose: assembles a byte stream into 32-bit words and writes them to consecutive memory words.
// Latency: last byte accepted at edge N -> mem_we in cycle N+1 -> done in cycle N+2 (one cycle later with VERIFY_EN).
// Backpressure: byte_ready is high only while assembling a word; a byte offered while byte_ready=0 must be held by the source.
//
// Ports: clk/reset (async active-high); start, base_addr, word_count request a load;
//        byte_valid/byte_data/byte_ready form the byte stream handshake;
//        mem_we/mem_addr/mem_wdata drive the memory write port, mem_rdata is its read data;
//        busy (not idle), done (one-cycle end pulse), error (sticky readback mismatch).
// Optional build macro: VERIFY_EN adds a readback CHECK cycle after every write.
module mem_stream_loader #(
  parameter int CNT_WIDTH  = 16,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t               state;
  logic [31:0]          base_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] index_q;
  logic [1:0]           byte_cnt;
  logic [31:0]          asm_q;

  logic [31:0]          asm_next;
  logic                 byte_take;
  logic                 last_word;

  // Little endian shifts bytes in from the top so the first byte ends in 7:0
  // after four shifts; big endian shifts in from the bottom so it ends in 31:24.
  always_comb begin
    asm_next = asm_q;
    if (BIG_ENDIAN != 0) asm_next = {asm_q[23:0], byte_data};
    else                 asm_next = {byte_data, asm_q[31:8]};
  end

  // byte_ready is only ever set while in LOAD, so this is the acceptance strobe.
  assign byte_take = byte_valid & byte_ready;
  // count_q is never 0 outside IDLE/FINISH, so count-1 cannot underflow here.
  assign last_word = (index_q == count_q - CNT_WIDTH'(1));

`ifdef VERIFY_EN
  logic error_q;
  assign error = error_q;
`else
  logic unused_rdata;
  assign error        = 1'b0;
  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      index_q    <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef VERIFY_EN
      error_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            index_q  <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            busy     <= 1'b1;
`ifdef VERIFY_EN
            error_q  <= 1'b0;
`endif
            if (word_count == '0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state      <= S_LOAD;
              byte_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (byte_take) begin
            asm_q    <= asm_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Word complete: present it to memory next cycle, stop accepting bytes.
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= base_q + 32'(index_q);
              mem_wdata  <= asm_next;
            end
          end
        end

        S_WRITE: begin
          mem_we <= 1'b0;
`ifdef VERIFY_EN
          state  <= S_CHECK;
`else
          if (last_word) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else begin
            index_q    <= index_q + CNT_WIDTH'(1);
            state      <= S_LOAD;
            byte_ready <= 1'b1;
          end
`endif
        end

        S_CHECK: begin
`ifdef VERIFY_EN
          // mem_addr/mem_wdata still hold the word just committed, so the
          // combinational read data must equal mem_wdata.
          if (mem_rdata != mem_wdata) begin
            error_q <= 1'b1;
            state   <= S_FINISH;
            done    <= 1'b1;
          end else if (last_word) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else begin
            index_q    <= index_q + CNT_WIDTH'(1);
            state      <= S_LOAD;
            byte_ready <= 1'b1;
          end
`else
          state <= S_IDLE;
`endif
        end

        S_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Purpose: self-checking bench for mem_stream_loader with an expected-write scoreboard and memory model.
// Latency: checks the byte->write->done timing of every load directly.
// Backpressure: byte source holds each byte until byte_ready is seen high.
module tb_mem_stream_loader;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   base_addr;
  logic [CW-1:0] word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  mem_stream_loader #(.CNT_WIDTH(CW), .BIG_ENDIAN(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Memory model: word array with optional corruption of one address on readback.
  logic [31:0] mem [0:15];
  logic        corrupt_en = 1'b0;
  logic [31:0] bad_addr   = 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[3:0]] ^ ((corrupt_en && mem_addr == bad_addr) ? 32'h1 : 32'h0);

  // Scoreboard of writes the loads must produce, in order.
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] last_waddr = 32'h0;
  int          wr_count   = 0;
  logic        prev_we    = 1'b0;
  logic        prev_done  = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wr_count++;
        last_waddr = mem_addr;
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=0x%08h required=no write", mem_addr);
        end else begin
          check("write_addr", mem_addr, exp_addr.pop_front());
          check("write_data", mem_wdata, exp_data.pop_front());
        end
      end
      check("we_single_cycle", 32'(prev_we & mem_we), 32'h0);
      check("done_single_cycle", 32'(prev_done & done), 32'h0);
      check("ready_implies_busy", 32'(byte_ready & ~busy), 32'h0);
      check("no_ready_during_write", 32'(byte_ready & mem_we), 32'h0);
      prev_we   = mem_we;
      prev_done = done;
    end else begin
      prev_we   = 1'b0;
      prev_done = 1'b0;
    end
  end

  function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
    return (base * 32'h9E3779B1) ^ (32'(i) * 32'h01234567) ^ 32'h5A5A5A5A;
  endfunction

  // All tasks enter and leave just after a falling edge.
  task automatic do_start(input logic [31:0] base, input logic [CW-1:0] cnt, input bit with_byte);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    if (with_byte) begin
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
    end
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tmo;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    tmo = 0;
    while (byte_ready !== 1'b1 && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    check("byte_ready_timeout", 32'(byte_ready), 32'h1);
    if (byte_ready === 1'b1) @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] base, input int n, input int gapmax,
                          input bit poke, input bit with_byte);
    logic [31:0] w;
    int k;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + 32'(i));
      exp_data.push_back(word_of(base, i));
    end
    do_start(base, CW'(n), with_byte);
    check("busy_after_start", 32'(busy), 32'h1);
    check("ready_after_start", 32'(byte_ready), 32'h1);
    check("error_cleared", 32'(error), 32'h0);
    k = 0;
    for (int i = 0; i < n; i++) begin
      w = word_of(base, i);
      for (int b = 0; b < 4; b++) begin
        if (poke && k == 1) begin
          start      = 1'b1;
          base_addr  = 32'h55;
          word_count = CW'(1);
        end
        send_byte(w[8*b +: 8], k % (gapmax + 1));
        start = 1'b0;
        k++;
      end
      check("we_after_last_byte", 32'(mem_we), 32'h1);
      check("done_during_write", 32'(done), 32'h0);
`ifdef VERIFY_EN
      @(negedge clk);
      check("check_cycle_we", 32'(mem_we), 32'h0);
`endif
      if (i == n - 1) begin
        @(negedge clk);
        check("done_after_write", 32'(done), 32'h1);
        check("busy_in_finish", 32'(busy), 32'h1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_done", 32'(done), 32'h0);
      end
    end
    check("writes_outstanding", 32'(exp_addr.size()), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_error"}, 32'(error), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int wr_before;
    logic [31:0] w2;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = 32'h0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single word with hand-computed result.
    exp_addr.push_back(32'h4);
    exp_data.push_back(32'h12345678);
    do_start(32'h4, CW'(1), 1'b0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    check("t1_we", 32'(mem_we), 32'h1);
    check("t1_addr", mem_addr, 32'h4);
    check("t1_wdata", mem_wdata, 32'h12345678);
`ifdef VERIFY_EN
    @(negedge clk);
`endif
    @(negedge clk);
    check("t1_done", 32'(done), 32'h1);
    check("t1_we_held_low", 32'(mem_we), 32'h0);
    check("t1_addr_held", mem_addr, 32'h4);
    check("t1_wdata_held", mem_wdata, 32'h12345678);
    @(negedge clk);
    check("t1_busy_low", 32'(busy), 32'h0);

    // Three words with 0..3 idle cycles between bytes.
    wr_before = wr_count;
    run_load(32'h0, 3, 3, 1'b0, 1'b0);
    check("t2_write_count", 32'(wr_count - wr_before), 32'd3);

    // Zero count: straight to done, no writes, never ready.
    wr_before  = wr_count;
    start      = 1'b1;
    base_addr  = 32'h30;
    word_count = '0;
    @(negedge clk);
    start = 1'b0;
    check("t3_done", 32'(done), 32'h1);
    check("t3_busy", 32'(busy), 32'h1);
    check("t3_ready", 32'(byte_ready), 32'h0);
    @(negedge clk);
    check("t3_done_end", 32'(done), 32'h0);
    check("t3_busy_end", 32'(busy), 32'h0);
    check("t3_ready_end", 32'(byte_ready), 32'h0);
    check("t3_no_write", 32'(wr_count - wr_before), 32'd0);

    // Reset after two bytes: immediate zeros, nothing written, clean restart.
    wr_before = wr_count;
    do_start(32'h8, CW'(1), 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t4_no_write", 32'(wr_count - wr_before), 32'd0);
    run_load(32'h8, 1, 1, 1'b0, 1'b0);
    check("t4_restart_count", 32'(wr_count - wr_before), 32'd1);

    // Address wrap past 0xFFFFFFFF.
    run_load(32'hFFFFFFFF, 2, 0, 1'b0, 1'b0);
    check("t5_wrap_addr", last_waddr, 32'h0);

    // Start while busy and start with a simultaneous byte are both ignored.
    run_load(32'h40, 2, 1, 1'b1, 1'b1);

    // Maximum count for this width.
    wr_before = wr_count;
    run_load(32'h100, 15, 0, 1'b0, 1'b0);
    check("t7_max_count", 32'(wr_count - wr_before), 32'd15);

`ifdef VERIFY_EN
    // Readback mismatch on word 1 of 3 aborts the load.
    corrupt_en = 1'b1;
    bad_addr   = 32'h21;
    exp_addr.push_back(32'h20);
    exp_data.push_back(word_of(32'h20, 0));
    exp_addr.push_back(32'h21);
    exp_data.push_back(word_of(32'h20, 1));
    wr_before = wr_count;
    do_start(32'h20, CW'(3), 1'b0);
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 4; b++) send_byte(word_of(32'h20, i) >> (8 * b), 0);
      check("v_we", 32'(mem_we), 32'h1);
      @(negedge clk);
      check("v_check_we", 32'(mem_we), 32'h0);
      check("v_check_addr", mem_addr, 32'h20 + 32'(i));
      check("v_error_in_check", 32'(error), 32'h0);
    end
    @(negedge clk);
    check("v_done", 32'(done), 32'h1);
    check("v_error", 32'(error), 32'h1);
    w2 = word_of(32'h20, 2);
    byte_valid = 1'b1;
    byte_data  = w2[7:0];
    repeat (8) begin
      @(negedge clk);
      check("v_no_ready", 32'(byte_ready), 32'h0);
    end
    byte_valid = 1'b0;
    check("v_error_sticky", 32'(error), 32'h1);
    check("v_write_count", 32'(wr_count - wr_before), 32'd2);
    corrupt_en = 1'b0;
    run_load(32'h28, 1, 0, 1'b0, 1'b0);
`endif

    check("final_error", 32'(error), 32'h0);
    check("final_busy", 32'(busy), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
